// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch interval measurement block.
package stopwatch_pkg;

   // FSM encoding: IDLE waits for a start, RUN counts, HOLD presents the result.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   // Counter ops: the saturating maximum is all-ones at the instantiated width,
   // derived inside the counter so the counter stays reusable at any WIDTH.

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: clear wins over enable; at all-ones a further
// increment holds the value and sets a sticky saturated flag until cleared.
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             enable_i,
   output logic [WIDTH-1:0] value_o,
   output logic             saturated_o
);

   localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] value_d, value_q;
   logic             sat_d, sat_q;

   // Next count: clear, saturate at all-ones, or increment.
   always_comb begin
      value_d = value_q;
      sat_d   = sat_q;
      if (clear_i) begin
         value_d = '0;
         sat_d   = 1'b0;
      end else if (enable_i) begin
         if (value_q == MAX_VAL) begin
            sat_d = 1'b1;
         end else begin
            value_d = value_q + ONE;
         end
      end
   end

   // Counter state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         value_q <= '0;
         sat_q   <= 1'b0;
      end else begin
         value_q <= value_d;
         sat_q   <= sat_d;
      end
   end

   assign value_o     = value_q;
   assign saturated_o = sat_q;

endmodule

// File: rtl/stopwatch.sv
// Stopwatch: counts clock edges between a start and a stop event and hands
// the count out over a valid/ready handshake.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | waiting for start; stop is ignored
//   RUN     | counting; stop captures the result, start restarts from 0
//   HOLD    | result presented with valid_o; frozen until ready_i
module stopwatch
   import stopwatch_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic             stop_i,
   output logic [WIDTH-1:0] result_o,
   output logic             overflow_o,
   output logic             valid_o,
   input  logic             ready_i,
   output logic             busy_o,
   output logic             start_ignored_o
);

   state_e           state_d, state_q;
   logic [WIDTH-1:0] result_d, result_q;
   logic             ovf_d, ovf_q;
   logic             valid_d, valid_q;
   logic             busy_d, busy_q;
   logic             ign_d, ign_q;
   logic             cnt_clear, cnt_en;
   logic [WIDTH-1:0] cnt_value;
   logic             cnt_sat;

   sat_counter #(.WIDTH(WIDTH)) u_cnt (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .clear_i     (cnt_clear),
      .enable_i    (cnt_en),
      .value_o     (cnt_value),
      .saturated_o (cnt_sat)
   );

   // Next-state, counter control and output-register next values.
   // A stop in RUN is captured without incrementing so the result equals
   // the number of edges after the start at which stop was low.
   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      ovf_d     = ovf_q;
      valid_d   = valid_q;
      ign_d     = 1'b0;
      cnt_clear = 1'b0;
      cnt_en    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d   = ST_RUN;
               cnt_clear = 1'b1;
            end
         end
         ST_RUN: begin
            if (stop_i) begin
               state_d  = ST_HOLD;
               result_d = cnt_value;
               ovf_d    = cnt_sat;
               valid_d  = 1'b1;
               ign_d    = start_i;
            end else if (start_i) begin
               cnt_clear = 1'b1;
            end else begin
               cnt_en = 1'b1;
            end
         end
         ST_HOLD: begin
            if (ready_i) begin
               valid_d = 1'b0;
               if (start_i) begin
                  state_d   = ST_RUN;
                  cnt_clear = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (start_i) begin
               ign_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
         end
      endcase
      busy_d = (state_d == ST_RUN);
   end

   // State and registered outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= ST_IDLE;
         result_q <= '0;
         ovf_q    <= 1'b0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         ign_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         ign_q    <= ign_d;
      end
   end

   assign result_o        = result_q;
   assign overflow_o      = ovf_q;
   assign valid_o         = valid_q;
   assign busy_o          = busy_q;
   assign start_ignored_o = ign_q;

endmodule

// File: tb/tb_stopwatch.sv
// Directed self-checking bench for the stopwatch with a result scoreboard.
module tb_stopwatch;

   localparam int W = 8;

   logic         clk_i = 1'b0;
   logic         rst_ni = 1'b0;
   logic         start_i = 1'b0;
   logic         stop_i = 1'b0;
   logic         ready_i = 1'b0;
   logic [W-1:0] result_o;
   logic         overflow_o;
   logic         valid_o;
   logic         busy_o;
   logic         start_ignored_o;

   int           n_tests = 0;
   int           n_fail = 0;
   logic [W:0]   sb_q[$];
   logic [W:0]   exp_e;

   stopwatch #(.WIDTH(W)) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .start_i         (start_i),
      .stop_i          (stop_i),
      .result_o        (result_o),
      .overflow_o      (overflow_o),
      .valid_o         (valid_o),
      .ready_i         (ready_i),
      .busy_o          (busy_o),
      .start_ignored_o (start_ignored_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #500000;
      $display("FAIL watchdog: run did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(negedge clk_i);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Start at E0, stop low for n edges, stop high at E(n+1); push the expected result.
   task automatic measure(input int n);
      start_i = 1'b1;
      stop_i  = 1'b0;
      step();
      start_i = 1'b0;
      repeat (n) step();
      stop_i = 1'b1;
      step();
      stop_i = 1'b0;
      if (n > 255) sb_q.push_back({1'b1, 8'd255});
      else         sb_q.push_back({1'b0, n[7:0]});
   endtask

   // Wait (bounded) for valid_o, then pop and compare against the scoreboard.
   task automatic take(input string tag);
      for (int i = 0; i < 4 && !valid_o; i++) step();
      chk({tag, "_valid"}, valid_o, 1);
      if (sb_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 0, 1);
      end else begin
         exp_e = sb_q.pop_front();
         chk({tag, "_result"}, result_o, exp_e[W-1:0]);
         chk({tag, "_ovf"}, overflow_o, exp_e[W]);
      end
   endtask

   task automatic give_ready(input string tag);
      ready_i = 1'b1;
      step();
      ready_i = 1'b0;
      chk({tag, "_valid_drop"}, valid_o, 0);
      chk({tag, "_idle_busy"}, busy_o, 0);
   endtask

   initial begin
      // Reset state
      #1;
      chk("rst_result", result_o, 0);
      chk("rst_valid", valid_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_ign", start_ignored_o, 0);
      step();
      step();
      rst_ni = 1'b1;
      step();

      // Reset mid-RUN at count 5 discards everything
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      repeat (5) step();
      chk("midrun_busy", busy_o, 1);
      #2 rst_ni = 1'b0;
      #1;
      chk("midrst_busy", busy_o, 0);
      chk("midrst_valid", valid_o, 0);
      chk("midrst_result", result_o, 0);
      chk("midrst_ovf", overflow_o, 0);
      step();
      rst_ni = 1'b1;
      stop_i = 1'b1;
      repeat (3) step();
      stop_i = 1'b0;
      chk("post_rst_stop_valid", valid_o, 0);
      chk("post_rst_stop_busy", busy_o, 0);

      // Basic: 25 edges, result held for 10 cycles under back-pressure
      measure(25);
      take("basic25");
      for (int i = 0; i < 10; i++) begin
         step();
         chk("hold_result", result_o, 25);
         chk("hold_valid", valid_o, 1);
      end
      give_ready("basic25");

      // Timer loopback counts
      measure(0);   take("loop0");   give_ready("loop0");
      measure(1);   take("loop1");   give_ready("loop1");
      measure(7);   take("loop7");   give_ready("loop7");
      measure(200); take("loop200"); give_ready("loop200");

      // Saturation boundary
      measure(255); take("sat255"); give_ready("sat255");
      measure(256); take("sat256"); give_ready("sat256");
      measure(260); take("sat260"); give_ready("sat260");

      // Stop on the same edge as start in IDLE is ignored
      start_i = 1'b1;
      stop_i  = 1'b1;
      step();
      start_i = 1'b0;
      stop_i  = 1'b0;
      chk("idle_stop_busy", busy_o, 1);
      chk("idle_stop_valid", valid_o, 0);
      repeat (2) step();
      stop_i = 1'b1;
      step();
      stop_i = 1'b0;
      sb_q.push_back({1'b0, 8'd2});
      take("idle_stop"); give_ready("idle_stop");

      // Restart at count 9, stop 4 edges later -> 3
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      repeat (9) step();
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      repeat (3) step();
      stop_i = 1'b1;
      step();
      stop_i = 1'b0;
      sb_q.push_back({1'b0, 8'd3});
      take("restart"); give_ready("restart");

      // Start and stop together in RUN: stop wins, start flagged as ignored
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      repeat (4) step();
      start_i = 1'b1;
      stop_i  = 1'b1;
      step();
      start_i = 1'b0;
      stop_i  = 1'b0;
      sb_q.push_back({1'b0, 8'd4});
      chk("collide_ign", start_ignored_o, 1);
      take("collide");
      step();
      chk("collide_ign_one_cycle", start_ignored_o, 0);
      give_ready("collide");

      // Back-pressure: ignored start in HOLD, then back-to-back start with ready
      measure(6);
      take("bp6");
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      chk("bp_ign", start_ignored_o, 1);
      chk("bp_result_kept", result_o, 6);
      chk("bp_valid_kept", valid_o, 1);
      step();
      chk("bp_ign_clear", start_ignored_o, 0);
      start_i = 1'b1;
      ready_i = 1'b1;
      step();
      start_i = 1'b0;
      ready_i = 1'b0;
      chk("b2b_busy", busy_o, 1);
      chk("b2b_valid", valid_o, 0);
      chk("b2b_ign", start_ignored_o, 0);
      repeat (2) step();
      stop_i = 1'b1;
      step();
      stop_i = 1'b0;
      sb_q.push_back({1'b0, 8'd2});
      take("b2b");
      give_ready("b2b");

      chk("sb_drained", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
